// File: rtl/encoder_8to3_seq.sv
// Sequential 8-to-3 priority encoder: captures a request vector on load and
// emits each set bit's index once over a valid/ready handshake.
module encoder_8to3_seq #(
  parameter int unsigned PRIO_HIGH = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  input  logic       load,
  input  logic       ready,
  output logic [2:0] s,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic       zero,
  output logic       ovf
);

  typedef enum logic [0:0] {StIdle, StServe} state_e;

  state_e     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] s_q, s_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       zero_q, zero_d;
  logic       ovf_q, ovf_d;

  // Index of the set bit to serve next; the last match in scan order wins.
  function automatic logic [2:0] pick(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (PRIO_HIGH != 0) begin
        if (v[i]) idx = 3'(i);
      end else begin
        if (v[7-i]) idx = 3'(7 - i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    s_d     = s_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    zero_d  = 1'b0;
    ovf_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          if (d != 8'h00) begin
            pend_d  = d;
            state_d = StServe;
            s_d     = pick(d);
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      StServe: begin
        // Loads are only taken in idle, including on the final acceptance.
        ovf_d = load;
        if (ready) begin
          pend_d = pend_q & ~(8'b1 << s_q);
          if (pend_d == 8'h00) begin
            state_d = StIdle;
            s_d     = 3'b000;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            s_d = pick(pend_d);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pend_q  <= 8'h00;
      s_q     <= 3'b000;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s     = s_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign zero  = zero_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Directed bench: two encoders (low and high priority) share one stimulus stream.
module tb_encoder_8to3_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d;
  logic       load;
  logic       ready;
  logic [2:0] s_lo, s_hi;
  logic       valid_lo, busy_lo, done_lo, zero_lo, ovf_lo;
  logic       valid_hi, busy_hi, done_hi, zero_hi, ovf_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder_8to3_seq #(.PRIO_HIGH(0)) u_dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .load  (load),
    .ready (ready),
    .s     (s_lo),
    .valid (valid_lo),
    .busy  (busy_lo),
    .done  (done_lo),
    .zero  (zero_lo),
    .ovf   (ovf_lo)
  );

  encoder_8to3_seq #(.PRIO_HIGH(1)) u_dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .load  (load),
    .ready (ready),
    .s     (s_hi),
    .valid (valid_hi),
    .busy  (busy_hi),
    .done  (done_hi),
    .zero  (zero_hi),
    .ovf   (ovf_hi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {s, valid, busy, done, zero, ovf} of the low-priority instance.
  task automatic chk_lo(input string tag, input logic [2:0] es, input logic ev, input logic eb,
                        input logic ed, input logic ez, input logic eo);
    chk(tag, {s_lo, valid_lo, busy_lo, done_lo, zero_lo, ovf_lo}, {es, ev, eb, ed, ez, eo});
  endtask

  task automatic chk_hi(input string tag, input logic [2:0] es, input logic ev, input logic eb,
                        input logic ed, input logic ez, input logic eo);
    chk(tag, {s_hi, valid_hi, busy_hi, done_hi, zero_hi, ovf_hi}, {es, ev, eb, ed, ez, eo});
  endtask

  initial begin
    rst_n = 1'b0; d = 8'h00; load = 1'b0; ready = 1'b0;
    tick(); tick();
    chk_lo("reset_lo", 3'd0, 0, 0, 0, 0, 0);
    chk_hi("reset_hi", 3'd0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // A4 = bits 2,5,7: low order 2,5,7 and high order 7,5,2.
    d = 8'b1010_0100; load = 1'b1; ready = 1'b1;
    tick(); load = 1'b0;
    chk_lo("a4_lo_s2", 3'd2, 1, 1, 0, 0, 0);
    chk_hi("a4_hi_s7", 3'd7, 1, 1, 0, 0, 0);
    tick();
    chk_lo("a4_lo_s5", 3'd5, 1, 1, 0, 0, 0);
    chk_hi("a4_hi_s5", 3'd5, 1, 1, 0, 0, 0);
    tick();
    chk_lo("a4_lo_s7", 3'd7, 1, 1, 0, 0, 0);
    chk_hi("a4_hi_s2", 3'd2, 1, 1, 0, 0, 0);
    tick();
    chk_lo("a4_lo_done", 3'd0, 0, 0, 1, 0, 0);
    chk_hi("a4_hi_done", 3'd0, 0, 0, 1, 0, 0);
    tick();
    chk_lo("a4_lo_idle", 3'd0, 0, 0, 0, 0, 0);

    // Single-hot with backpressure: s=4 held for 4 stalled cycles.
    d = 8'h10; load = 1'b1; ready = 1'b0;
    tick(); load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_lo("stall_hold", 3'd4, 1, 1, 0, 0, 0);
      if (i < 3) tick();
    end
    ready = 1'b1;
    tick();
    chk_lo("stall_done", 3'd0, 0, 0, 1, 0, 0);
    chk_hi("stall_done_hi", 3'd0, 0, 0, 1, 0, 0);
    tick();
    chk_lo("stall_idle", 3'd0, 0, 0, 0, 0, 0);

    // Empty load.
    d = 8'h00; load = 1'b1;
    tick(); load = 1'b0;
    chk_lo("zero_pulse", 3'd0, 0, 0, 0, 1, 0);
    tick();
    chk_lo("zero_clear", 3'd0, 0, 0, 0, 0, 0);

    // FF with a load dropped at the third transfer.
    d = 8'hFF; load = 1'b1;
    tick(); load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_lo("ff_seq", 3'(k), 1, 1, 0, 0, (k == 3) ? 1'b1 : 1'b0);
      if (k == 2) begin
        load = 1'b1; d = 8'h01;
      end
      tick();
      load = 1'b0;
    end
    chk_lo("ff_done", 3'd0, 0, 0, 1, 0, 0);
    tick();
    chk_lo("ff_no_extra", 3'd0, 0, 0, 0, 0, 0);

    // Load coinciding with the final acceptance is dropped.
    d = 8'h01; load = 1'b1;
    tick(); load = 1'b0;
    chk_lo("last_s0", 3'd0, 1, 1, 0, 0, 0);
    d = 8'h08; load = 1'b1;
    tick(); load = 1'b0;
    chk_lo("last_ovf_done", 3'd0, 0, 0, 1, 0, 1);
    tick();
    chk_lo("last_dropped", 3'd0, 0, 0, 0, 0, 0);

    // Reset mid-serve, with load and ready also asserted.
    d = 8'hFF; load = 1'b1;
    tick(); load = 1'b0;
    chk_lo("rst_s0", 3'd0, 1, 1, 0, 0, 0);
    tick();
    chk_lo("rst_s1", 3'd1, 1, 1, 0, 0, 0);
    tick();
    chk_lo("rst_s2", 3'd2, 1, 1, 0, 0, 0);
    rst_n = 1'b0; load = 1'b1; d = 8'h80;
    tick();
    chk_lo("rst_clear_lo", 3'd0, 0, 0, 0, 0, 0);
    chk_hi("rst_clear_hi", 3'd0, 0, 0, 0, 0, 0);
    rst_n = 1'b1; d = 8'h40;
    tick(); load = 1'b0;
    chk_lo("post_rst_load", 3'd6, 1, 1, 0, 0, 0);
    chk_hi("post_rst_load_hi", 3'd6, 1, 1, 0, 0, 0);
    tick();
    chk_lo("post_rst_done", 3'd0, 0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_8to3_seq.md
ENCODER_8TO3_SEQ -- requirements
Module: encoder_8to3_seq

Interface
REQ-001 The block SHALL have parameter PRIO_HIGH, default 0: 0 = serve lowest set bit first, 1 = serve highest set bit first.
REQ-002 The block SHALL have a clock port: clk, input, 1 bit, single clock, all state on rising edge.
REQ-003 The block SHALL have a reset port: rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-004 The block SHALL have port d: input, 8 bits, request vector, one bit per line, any number of bits set.
REQ-005 The block SHALL have port load: input, 1 bit, capture d into the pending register when the block is idle.
REQ-006 The block SHALL have port s: output, 3 bits, encoded index of the line currently offered.
REQ-007 The block SHALL have port valid: output, 1 bit, s holds a valid index.
REQ-008 The block SHALL have port ready: input, 1 bit, consumer accepts s when valid && ready.
REQ-009 The block SHALL have port busy: output, 1 bit, pending register non-empty (state SERVE).
REQ-010 The block SHALL have port done: output, 1 bit, one-cycle pulse when the last pending index is accepted.
REQ-011 The block SHALL have port zero: output, 1 bit, one-cycle pulse when a load captured d == 8'h00.
REQ-012 The block SHALL have port ovf: output, 1 bit, one-cycle pulse when load is asserted while busy (request dropped).

Function
REQ-013 The block SHALL have two states, IDLE and SERVE, with a pend[7:0] register; all outputs SHALL be registered.
REQ-014 In IDLE with load=1 and d!=0, the block SHALL set pend=d and go to SERVE; valid and s SHALL appear the next cycle (latency 1).
REQ-015 In IDLE with load=1 and d==0, the block SHALL stay in IDLE, leave pend at 0, and pulse zero for one cycle.
REQ-016 In SERVE, s SHALL equal the index of the lowest set bit of pend (PRIO_HIGH=0) or the highest set bit (PRIO_HIGH=1); the mapping SHALL be index k <-> d[k], so s=3'b000 <-> bit 0.
REQ-017 In SERVE, valid SHALL be 1 every cycle; s and valid SHALL hold stable while ready=0.
REQ-018 On valid && ready, the block SHALL clear pend[s]; next cycle s SHALL present the next index (back-to-back, one index per cycle at ready=1).
REQ-019 When the accepted bit is the last set bit, the block SHALL pulse done in the next cycle, deassert valid and busy, and return to IDLE.
REQ-020 load in SERVE SHALL be ignored for data, pend SHALL be unchanged, and ovf SHALL pulse.
REQ-021 On load on the same cycle as the final acceptance (SERVE), the load SHALL be treated as ovf (dropped); a load is accepted only when the state is IDLE at the clock edge.
REQ-022 d=8'hFF SHALL produce 8 transfers; a single-hot d SHALL produce exactly 1 transfer and done.
REQ-023 The block SHALL emit each set bit of the captured d exactly once; no index outside the captured set SHALL be emitted.

Reset
REQ-024 With rst_n=0 at a clk edge, the block SHALL set state=IDLE, pend=0, s=3'b000, and valid=busy=done=zero=ovf=0.
REQ-025 Reset asserted mid-SERVE SHALL abandon the remaining indices with no done pulse; the first cycle after release SHALL accept load.
REQ-026 rst_n SHALL dominate load and ready in the same cycle.

Verification
REQ-027 The bench SHALL drive load, d=8'b1010_0100, PRIO_HIGH=0, ready=1 and require s=2, 5, 7 on 3 consecutive valid cycles, done the cycle after 7, then busy=0.
REQ-028 The bench SHALL drive the same d with PRIO_HIGH=1 and require the order s=7, 5, 2.
REQ-029 The bench SHALL drive d=8'h10 with ready=0 for 4 cycles, then 1, and require s=4 with valid held for 4 cycles, one transfer, then done.
REQ-030 The bench SHALL drive load with d=8'h00 and require a zero pulse, valid=0, and busy=0.
REQ-031 The bench SHALL drive d=8'hFF, then load d=8'h01 at the 3rd transfer, and require an ovf pulse, 8 transfers s=0..7, and no extra s=0.
REQ-032 The bench SHALL drive d=8'hFF and assert rst_n=0 after 2 transfers, and require all outputs 0 the next cycle, no done, and a new load accepted right after release.
